// File: rtl/video_text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_text_pkg
// Description : Shared constants and types for the text-console sequencer:
//               command opcodes, control characters, FSM state encoding and
//               default screen geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package video_text_pkg;

    // Default screen geometry and fill glyph
    localparam int          DEF_COLS      = 40;
    localparam int          DEF_ROWS      = 30;
    localparam logic [7:0]  DEF_FILL_CHAR = 8'h20;

    // Command opcodes
    localparam logic [1:0]  OP_PUTC       = 2'd0;
    localparam logic [1:0]  OP_CLEAR      = 2'd1;
    localparam logic [1:0]  OP_SET_CURSOR = 2'd2;
    localparam logic [1:0]  OP_SCROLL     = 2'd3;

    // Control characters interpreted by PUTC
    localparam logic [7:0]  CH_LF         = 8'h0A;
    localparam logic [7:0]  CH_CR         = 8'h0D;
    localparam logic [7:0]  CH_BS         = 8'h08;
    localparam logic [7:0]  CH_TAB        = 8'h09;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUT  = 2'd1,
        ST_FILL = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/text_row_map.sv
`default_nettype none
// ============================================================================
// Module      : text_row_map
// Description : Maps a logical row to a physical RAM row, (row + base) mod
//               ROWS, with a single conditional subtract instead of a divider.
//               Also used by the display side to remap scanned rows.
// Revision    : 1.0 - initial release
// ============================================================================
module text_row_map #(
    parameter int ROWS = 30
) (
    input  logic [4:0] row_i,
    input  logic [4:0] base_i,
    output logic [4:0] phys_o
);

    logic [5:0] w_sum;

    // Both operands are below ROWS, so one subtract is enough to wrap
    assign w_sum  = {1'b0, row_i} + {1'b0, base_i};
    assign phys_o = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];

endmodule
`default_nettype wire

// File: rtl/video_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : video_text_engine
// Description : Text-console command sequencer. Tracks cursor and circular
//               row base (hardware scroll) and emits all character-RAM byte
//               writes for PUTC, CLEAR and SCROLL commands.
//               Optional macro VIDEO_TEXT_TAB_EN: 0x09 advances the cursor to
//               the next multiple of 8 instead of printing a glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module video_text_engine
    import video_text_pkg::*;
#(
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    output logic        ram_we,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic [4:0]  row_base,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam logic [5:0] C_LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

    state_e      state_q;
    logic [5:0]  cursor_x_q;
    logic [4:0]  cursor_y_q;
    logic [4:0]  row_base_q;
    logic        ram_we_q;
    logic [10:0] ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic [4:0]  fill_row_q;
    logic [5:0]  fill_col_q;
    logic        fill_clear_q;
    logic        scroll_pend_q;

    logic [7:0]  w_char;
    logic [4:0]  w_phys_y;
    logic [4:0]  w_rb_inc;
    logic [5:0]  w_set_x;
    logic [4:0]  w_set_y;
    logic        w_newline;
    logic        w_start_scroll;
    logic        w_unused_arg;

    logic [5:0]  put_x_d;
    logic [4:0]  put_y_d;
    logic        put_we_d;
    logic        put_scroll_d;
    logic [5:0]  fill_col_d;
    logic [4:0]  fill_row_d;
    logic        fill_done_d;

    assign w_char       = cmd_arg[7:0];
    assign w_unused_arg = ^cmd_arg[15:13];
    assign w_rb_inc     = (row_base_q == C_LAST_ROW) ? 5'd0 : row_base_q + 5'd1;
    assign w_set_x      = (cmd_arg[5:0]  > C_LAST_COL) ? C_LAST_COL : cmd_arg[5:0];
    assign w_set_y      = (cmd_arg[12:8] > C_LAST_ROW) ? C_LAST_ROW : cmd_arg[12:8];

    text_row_map #(
        .ROWS   (ROWS)
    ) u_row_map (
        .row_i  (cursor_y_q),
        .base_i (row_base_q),
        .phys_o (w_phys_y)
    );

`ifdef VIDEO_TEXT_TAB_EN
    logic [6:0] w_tab_x;
    assign w_tab_x = {1'b0, cursor_x_q[5:3], 3'b000} + 7'd8;
`endif

    // Cursor motion and write/scroll decision for the character on cmd_arg
    always_comb begin
        put_x_d      = cursor_x_q;
        put_y_d      = cursor_y_q;
        put_we_d     = 1'b0;
        put_scroll_d = 1'b0;
        w_newline    = 1'b0;
        case (w_char)
            CH_LF: w_newline = 1'b1;
            CH_CR: put_x_d = 6'd0;
            CH_BS: if (cursor_x_q != 6'd0) put_x_d = cursor_x_q - 6'd1;
`ifdef VIDEO_TEXT_TAB_EN
            CH_TAB: begin
                if (w_tab_x >= 7'(COLS)) w_newline = 1'b1;
                else                     put_x_d   = w_tab_x[5:0];
            end
`endif
            default: begin
                put_we_d = 1'b1;
                if (cursor_x_q == C_LAST_COL) w_newline = 1'b1;
                else                          put_x_d   = cursor_x_q + 6'd1;
            end
        endcase
        // At the bottom row a newline scrolls content rather than moving down
        if (w_newline) begin
            put_x_d = 6'd0;
            if (cursor_y_q != C_LAST_ROW) put_y_d      = cursor_y_q + 5'd1;
            else                          put_scroll_d = 1'b1;
        end
    end

    // Fill walker: next cell and end-of-fill detection (one row or whole screen)
    always_comb begin
        fill_col_d  = fill_col_q + 6'd1;
        fill_row_d  = fill_row_q;
        fill_done_d = (fill_col_q == C_LAST_COL) &&
                      (!fill_clear_q || (fill_row_q == C_LAST_ROW));
        if (fill_col_q == C_LAST_COL) begin
            fill_col_d = 6'd0;
            fill_row_d = fill_row_q + 5'd1;
        end
    end

    // A scroll starts from an idle SCROLL/newline, or right after a wrapping PUT
    always_comb begin
        w_start_scroll = 1'b0;
        case (state_q)
            ST_IDLE: w_start_scroll = cmd_valid &&
                         ((cmd_op == OP_SCROLL) ||
                          ((cmd_op == OP_PUTC) && put_scroll_d && !put_we_d));
            ST_PUT:  w_start_scroll = scroll_pend_q;
            default: w_start_scroll = 1'b0;
        endcase
    end

    // Sequencer FSM with registered RAM write port, cursor and row base
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cursor_x_q    <= 6'd0;
            cursor_y_q    <= 5'd0;
            row_base_q    <= 5'd0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= 11'd0;
            ram_wdata_q   <= 8'd0;
            fill_row_q    <= 5'd0;
            fill_col_q    <= 6'd0;
            fill_clear_q  <= 1'b0;
            scroll_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUTC: begin
                                cursor_x_q <= put_x_d;
                                cursor_y_q <= put_y_d;
                                if (put_we_d) begin
                                    state_q       <= ST_PUT;
                                    ram_we_q      <= 1'b1;
                                    ram_addr_q    <= {w_phys_y, cursor_x_q};
                                    ram_wdata_q   <= w_char;
                                    scroll_pend_q <= put_scroll_d;
                                end
                            end
                            OP_CLEAR: begin
                                state_q      <= ST_FILL;
                                row_base_q   <= 5'd0;
                                cursor_x_q   <= 6'd0;
                                cursor_y_q   <= 5'd0;
                                fill_row_q   <= 5'd0;
                                fill_col_q   <= 6'd0;
                                fill_clear_q <= 1'b1;
                                ram_we_q     <= 1'b1;
                                ram_addr_q   <= 11'd0;
                                ram_wdata_q  <= FILL_CHAR;
                            end
                            OP_SET_CURSOR: begin
                                cursor_x_q <= w_set_x;
                                cursor_y_q <= w_set_y;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PUT: begin
                    state_q  <= ST_IDLE;
                    ram_we_q <= 1'b0;
                end
                ST_FILL: begin
                    if (fill_done_d) begin
                        state_q  <= ST_IDLE;
                        ram_we_q <= 1'b0;
                    end else begin
                        fill_col_q <= fill_col_d;
                        fill_row_q <= fill_row_d;
                        ram_addr_q <= {fill_row_d, fill_col_d};
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ram_we_q <= 1'b0;
                end
            endcase
            // Scroll: advance row base and blank the old top row (new bottom)
            if (w_start_scroll) begin
                state_q       <= ST_FILL;
                row_base_q    <= w_rb_inc;
                fill_row_q    <= row_base_q;
                fill_col_q    <= 6'd0;
                fill_clear_q  <= 1'b0;
                scroll_pend_q <= 1'b0;
                ram_we_q      <= 1'b1;
                ram_addr_q    <= {row_base_q, 6'd0};
                ram_wdata_q   <= FILL_CHAR;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign row_base  = row_base_q;
    assign cursor_x  = cursor_x_q;
    assign cursor_y  = cursor_y_q;

endmodule
`default_nettype wire

// File: tb/tb_video_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_text_engine
// Description : Scoreboard bench for video_text_engine. Expected RAM writes
//               are queued by the stimulus; a monitor pops one per observed
//               write strobe. Cursor, row base and latency are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_text_engine;

    localparam logic [1:0] C_PUTC   = 2'd0;
    localparam logic [1:0] C_CLEAR  = 2'd1;
    localparam logic [1:0] C_SETCUR = 2'd2;
    localparam logic [1:0] C_SCROLL = 2'd3;

    logic        clk_cpu;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [4:0]  row_base;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int          checks;
    int          errors;
    int          wr_count;
    logic [18:0] exp_q[$];

    video_text_engine #(
        .COLS      (40),
        .ROWS      (30),
        .FILL_CHAR (8'h20)
    ) dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .row_base  (row_base),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk_cpu) begin
        if (!reset && ram_we) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%02h expected none",
                         ram_addr, ram_wdata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got addr 0x%03h data 0x%02h expected addr 0x%03h data 0x%02h",
                             ram_addr, ram_wdata, e[18:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] xy(input int x, input int y);
        return 16'(((y & 31) << 8) | (x & 63));
    endfunction

    task automatic push_wr(input int addr, input int data);
        exp_q.push_back({11'(addr), 8'(data)});
    endtask

    task automatic push_fill_row(input int prow);
        for (int c = 0; c < 40; c++) push_wr((prow << 6) | c, 8'h20);
    endtask

    // Issue one command; cyc = cycles from acceptance until ready again (idle op = 1)
    task automatic send(input logic [1:0] op, input logic [15:0] arg, output int cyc);
        int n;
        @(negedge clk_cpu);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk_cpu);
            n++;
        end
        @(posedge clk_cpu);
        #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (!cmd_ready && cyc < 3000) begin
            @(posedge clk_cpu);
            #1;
            cyc++;
        end
        chk("cmd_completes", 32'(cyc < 3000 && n < 100), 32'd1);
    endtask

    task automatic check_cursor(input string tag, input int x, input int y, input int rb);
        chk({tag, "_x"}, 32'(cursor_x), 32'(x));
        chk({tag, "_y"}, 32'(cursor_y), 32'(y));
        chk({tag, "_rb"}, 32'(row_base), 32'(rb));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        check_cursor(tag, 0, 0, 0);
    endtask

    initial begin
        int cyc;
        int base;
        checks    = 0;
        errors    = 0;
        wr_count  = 0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 16'd0;
        reset     = 1'b1;
        repeat (3) @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        #1;
        check_reset_state("reset");

        // Printable character at home position
        push_wr(11'h000, 8'h41);
        send(C_PUTC, 16'h0041, cyc);
        chk("putc_A_cyc", 32'(cyc), 32'd2);
        check_cursor("putc_A", 1, 0, 0);

        // Write at last column wraps cursor to next row, no fill
        send(C_SETCUR, xy(39, 5), cyc);
        chk("setcur_cyc", 32'(cyc), 32'd1);
        check_cursor("setcur_39_5", 39, 5, 0);
        push_wr(11'h167, 8'h5A);
        send(C_PUTC, 16'h005A, cyc);
        chk("putc_Z_cyc", 32'(cyc), 32'd2);
        check_cursor("putc_Z", 0, 6, 0);

        // Clamping of out-of-range cursor
        send(C_SETCUR, xy(63, 31), cyc);
        check_cursor("clamp", 39, 29, 0);

        // Newline mid-screen: no writes, stays ready
        send(C_SETCUR, xy(5, 3), cyc);
        send(C_PUTC, 16'h000A, cyc);
        chk("lf_mid_cyc", 32'(cyc), 32'd1);
        check_cursor("lf_mid", 0, 4, 0);

        // Newline at bottom scrolls: blank physical row 0
        send(C_SETCUR, xy(0, 29), cyc);
        push_fill_row(0);
        send(C_PUTC, 16'h000A, cyc);
        chk("lf_scroll_cyc", 32'(cyc), 32'd41);
        check_cursor("lf_scroll", 0, 29, 1);

        // Bottom logical row now maps to physical row 0
        push_wr(11'h000, 8'h42);
        send(C_PUTC, 16'h0042, cyc);
        check_cursor("putc_B", 1, 29, 1);

        // CR, then BS saturating at column 0
        send(C_PUTC, 16'h000D, cyc);
        chk("cr_cyc", 32'(cyc), 32'd1);
        check_cursor("cr", 0, 29, 1);
        send(C_PUTC, 16'h0008, cyc);
        check_cursor("bs_sat", 0, 29, 1);
        push_wr(11'h000, 8'h43);
        send(C_PUTC, 16'h0043, cyc);
        send(C_PUTC, 16'h0008, cyc);
        check_cursor("bs", 0, 29, 1);

        // Write at bottom-right: the char, then a scroll blanking physical row 1
        send(C_SETCUR, xy(39, 29), cyc);
        push_wr(11'h027, 8'h44);
        push_fill_row(1);
        send(C_PUTC, 16'h0044, cyc);
        chk("wrap_scroll_cyc", 32'(cyc), 32'd42);
        check_cursor("wrap_scroll", 0, 29, 2);

        // Tab: a glyph by default, a cursor jump when the option is built in
`ifdef VIDEO_TEXT_TAB_EN
        send(C_PUTC, 16'h0009, cyc);
        chk("tab_cyc", 32'(cyc), 32'd1);
        check_cursor("tab", 8, 29, 2);
`else
        push_wr(11'h040, 8'h09);
        send(C_PUTC, 16'h0009, cyc);
        chk("tab_cyc", 32'(cyc), 32'd2);
        check_cursor("tab", 1, 29, 2);
`endif

        // Full clear in row-major order
        for (int r = 0; r < 30; r++) push_fill_row(r);
        send(C_CLEAR, 16'h0000, cyc);
        chk("clear_cyc", 32'(cyc), 32'd1201);
        check_cursor("clear", 0, 0, 0);

        // 30 scrolls wrap the row base back to 0; cursor untouched
        for (int i = 0; i < 30; i++) begin
            push_fill_row(i);
            send(C_SCROLL, 16'h0000, cyc);
            if (i == 0) chk("scroll_cyc", 32'(cyc), 32'd41);
            if (i == 28) chk("scroll_rb29", 32'(row_base), 32'd29);
        end
        check_cursor("scroll30", 0, 0, 0);
        push_wr(11'h000, 8'h45);
        send(C_PUTC, 16'h0045, cyc);
        check_cursor("putc_E", 1, 0, 0);

        // Reset asserted in the middle of a clear
        for (int r = 0; r < 30; r++) push_fill_row(r);
        @(negedge clk_cpu);
        cmd_op    = C_CLEAR;
        cmd_arg   = 16'h0000;
        cmd_valid = 1'b1;
        @(posedge clk_cpu);
        #1;
        cmd_valid = 1'b0;
        base = wr_count;
        repeat (499) @(posedge clk_cpu);
        @(negedge clk_cpu);
        #1;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_writes", 32'(wr_count - base), 32'd500);
        reset = 1'b1;
        #1;
        check_reset_state("abort");
        exp_q.delete();
        @(negedge clk_cpu);
        reset = 1'b0;
        push_wr(11'h000, 8'h46);
        send(C_PUTC, 16'h0046, cyc);
        check_cursor("putc_F", 1, 0, 0);

        repeat (3) @(posedge clk_cpu);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
